fifo_write_arbiter: RTL and testbench

Shares the single write port of the byte FIFO between two producers that present data as one-cycle strobes, e.g. the UART receiver and the morse decoder. Each producer gets a one-word holding slot. A round-robin arbiter drains the slots into the FIFO only while the FIFO reports not-full, so an accepted word is never lost at the FIFO. Words that arrive while a producer's slot is still occupied are dropped and counted per producer.

---
 rtl/fifo_write_arbiter.sv | 145 ++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_write_arbiter
//  Purpose  : Shares the single write port of a byte FIFO between two
//             producers that present words as one-cycle strobes. Each
//             producer owns a one-word holding slot. A round-robin arbiter
//             drains the slots into the FIFO only while the FIFO is not
//             full. Words that arrive while a slot is still occupied are
//             dropped and counted in a per-producer saturating counter.
//  Ports    : clk_i, reset_i          clock, synchronous active-high reset
//             stb0_i/data0_i          producer 0 strobe and word
//             stb1_i/data1_i          producer 1 strobe and word
//             clr_drops_i             clear both drop counters
//             fifo_full_i             FIFO full flag
//             fifo_write_o/_wdata_o   FIFO write strobe and data
//             pend0_o/pend1_o         slot occupied flags
//             drop0_o/drop1_o         dropped-word counters
//  Revision : 1.0  initial release
// ============================================================================
module fifo_write_arbiter #(
    parameter int WORD_BITS = 8,
    parameter int CNT_BITS  = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 stb0_i,
    input  logic [WORD_BITS-1:0] data0_i,
    input  logic                 stb1_i,
    input  logic [WORD_BITS-1:0] data1_i,
    input  logic                 clr_drops_i,
    input  logic                 fifo_full_i,
    output logic                 fifo_write_o,
    output logic [WORD_BITS-1:0] fifo_wdata_o,
    output logic                 pend0_o,
    output logic                 pend1_o,
    output logic [CNT_BITS-1:0]  drop0_o,
    output logic [CNT_BITS-1:0]  drop1_o
);

    localparam logic [CNT_BITS-1:0] C_CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

    // Per-producer views gathered from the generate blocks below
    logic [1:0]           w_stb;
    logic [WORD_BITS-1:0] w_in_data   [2];
    logic [1:0]           w_valid;
    logic [WORD_BITS-1:0] w_slot_data [2];
    logic [CNT_BITS-1:0]  w_drop      [2];
    logic [1:0]           w_drain;

    logic last_grant_q;
    logic last_grant_d;
    logic w_grant;
    logic w_write;

    assign w_stb        = {stb1_i, stb0_i};
    assign w_in_data[0] = data0_i;
    assign w_in_data[1] = data1_i;

    // Round-robin grant: with both slots pending, the producer that was not
    // written last wins; otherwise whichever slot is pending. With no slot
    // pending the value is irrelevant because no write is issued.
    always_comb begin
        w_grant = w_valid[1];
        if (w_valid == 2'b11) begin
            w_grant = ~last_grant_q;
        end
    end

    // Reset gates the write so a held word is discarded rather than issued
    // in the reset cycle.
    assign w_write      = (|w_valid) & ~fifo_full_i & ~reset_i;
    assign fifo_write_o = w_write;
    assign fifo_wdata_o = w_write ? w_slot_data[w_grant] : {WORD_BITS{1'b0}};

    assign last_grant_d = w_write ? w_grant : last_grant_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_grant_q <= 1'b1;   // producer 0 wins the first contention
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    genvar n;
    generate
        for (n = 0; n < 2; n++) begin : g_prod
            logic                 valid_q;
            logic                 valid_d;
            logic [WORD_BITS-1:0] data_q;
            logic [WORD_BITS-1:0] data_d;
            logic [CNT_BITS-1:0]  drop_q;
            logic [CNT_BITS-1:0]  drop_d;

            assign w_drain[n] = w_write & (w_grant == 1'(n));

            always_comb begin
                valid_d = valid_q;
                data_d  = data_q;
                drop_d  = drop_q;
                // A slot draining this cycle can accept a new word on the
                // same edge, which is what lets back-to-back traffic avoid
                // drops.
                if (w_stb[n] && (!valid_q || w_drain[n])) begin
                    valid_d = 1'b1;
                    data_d  = w_in_data[n];
                end else begin
                    if (w_drain[n]) begin
                        valid_d = 1'b0;
                    end
                    if (w_stb[n] && (drop_q != {CNT_BITS{1'b1}})) begin
                        drop_d = drop_q + C_CNT_ONE;
                    end
                end
                if (clr_drops_i) begin
                    drop_d = {CNT_BITS{1'b0}};
                end
            end

            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    valid_q <= 1'b0;
                    data_q  <= {WORD_BITS{1'b0}};
                    drop_q  <= {CNT_BITS{1'b0}};
                end else begin
                    valid_q <= valid_d;
                    data_q  <= data_d;
                    drop_q  <= drop_d;
                end
            end

            assign w_valid[n]     = valid_q;
            assign w_slot_data[n] = data_q;
            assign w_drop[n]      = drop_q;
        end
    endgenerate

    // Status outputs read as zero while reset is held
    assign pend0_o = w_valid[0] & ~reset_i;
    assign pend1_o = w_valid[1] & ~reset_i;
    assign drop0_o = reset_i ? {CNT_BITS{1'b0}} : w_drop[0];
    assign drop1_o = reset_i ? {CNT_BITS{1'b0}} : w_drop[1];

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_write_arbiter
//  Purpose  : Self-checking bench for fifo_write_arbiter: directed vector
//             table, sustained alternation sequence, counter saturation on a
//             narrow-counter instance, and randomized traffic against a
//             behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_write_arbiter;

    typedef struct {
        bit       rst;
        bit       s0;
        bit [7:0] d0;
        bit       s1;
        bit [7:0] d1;
        bit       full;
        bit       clr;
        bit       e_wr;
        bit [7:0] e_wd;
        bit       e_p0;
        bit       e_p1;
        bit [7:0] e_r0;
        bit [7:0] e_r1;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default widths
    logic       rst = 1'b1, stb0 = 1'b0, stb1 = 1'b0, clr = 1'b0, full = 1'b0;
    logic [7:0] d0 = 8'h00, d1 = 8'h00;
    logic       wr, p0, p1;
    logic [7:0] wd, dr0, dr1;

    // Instance B: 2-bit drop counters
    logic       rst_b = 1'b1, stb0_b = 1'b0, stb1_b = 1'b0, clr_b = 1'b0, full_b = 1'b0;
    logic [7:0] d0_b = 8'h00, d1_b = 8'h00;
    logic       wr_b, p0_b, p1_b;
    logic [7:0] wd_b;
    logic [1:0] dr0_b, dr1_b;

    fifo_write_arbiter #(.WORD_BITS(8), .CNT_BITS(8)) u_dut (
        .clk_i(clk), .reset_i(rst),
        .stb0_i(stb0), .data0_i(d0), .stb1_i(stb1), .data1_i(d1),
        .clr_drops_i(clr), .fifo_full_i(full),
        .fifo_write_o(wr), .fifo_wdata_o(wd),
        .pend0_o(p0), .pend1_o(p1), .drop0_o(dr0), .drop1_o(dr1)
    );

    fifo_write_arbiter #(.WORD_BITS(8), .CNT_BITS(2)) u_dut_b (
        .clk_i(clk), .reset_i(rst_b),
        .stb0_i(stb0_b), .data0_i(d0_b), .stb1_i(stb1_b), .data1_i(d1_b),
        .clr_drops_i(clr_b), .fifo_full_i(full_b),
        .fifo_write_o(wr_b), .fifo_wdata_o(wd_b),
        .pend0_o(p0_b), .pend1_o(p1_b), .drop0_o(dr0_b), .drop1_o(dr1_b)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit r, bit s0, bit [7:0] a, bit s1, bit [7:0] b, bit f, bit c,
                                bit ew, bit [7:0] ewd, bit ep0, bit ep1, bit [7:0] er0, bit [7:0] er1);
        vec_t v;
        v.rst = r; v.s0 = s0; v.d0 = a; v.s1 = s1; v.d1 = b; v.full = f; v.clr = c;
        v.e_wr = ew; v.e_wd = ewd; v.e_p0 = ep0; v.e_p1 = ep1; v.e_r0 = er0; v.e_r1 = er1;
        return v;
    endfunction

    // ---------------- behavioural reference model ----------------
    // Each producer owns at most one pending word; the writer serves the
    // pending producer, preferring the one not served most recently.
    bit       m_pend [2];
    bit [7:0] m_word [2];
    int       m_drops[2];
    int       m_last;
    bit       e_wr;
    bit [7:0] e_wd;
    int       e_who;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = 0; m_word[k] = 0; m_drops[k] = 0;
        end
        m_last = 1;
    endtask

    task automatic model_eval(input bit r, input bit f);
        int pref;
        pref  = 1 - m_last;
        e_who = m_pend[pref] ? pref : 1 - pref;
        e_wr  = !r && (m_pend[0] || m_pend[1]) && !f;
        e_wd  = e_wr ? m_word[e_who] : 8'h00;
    endtask

    task automatic model_step(input bit r, input bit s0, input bit [7:0] a,
                              input bit s1, input bit [7:0] b, input bit c);
        bit       s [2];
        bit [7:0] w [2];
        if (r) begin
            model_reset();
            return;
        end
        s[0] = s0; s[1] = s1; w[0] = a; w[1] = b;
        for (int k = 0; k < 2; k++) begin
            bit served;
            served = e_wr && (e_who == k);
            if (served) m_pend[k] = 0;
            if (s[k]) begin
                if (!m_pend[k]) begin
                    m_pend[k] = 1; m_word[k] = w[k];
                end else if (m_drops[k] < 255) begin
                    m_drops[k]++;
                end
            end
        end
        if (c) begin
            m_drops[0] = 0; m_drops[1] = 0;
        end
        if (e_wr) m_last = e_who;
    endtask

    vec_t tbl[$];

    initial begin
        int n_wr;
        // ---------------- directed vector table ----------------
        //             rst s0 d0     s1 d1     full clr | wr wd     p0 p1 r0 r1
        tbl.push_back(mk(1, 0, 8'h00, 0, 8'h00, 0, 0,   0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h41, 0, 8'h00, 0, 0,   0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0,   1, 8'h41, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0,   0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 8'h00, 0, 8'h00, 0, 0,   0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hA0, 1, 8'hB1, 0, 0,   0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0,   1, 8'hA0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0,   1, 8'hB1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 8'hA0, 1, 8'hB1, 0, 0,   0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0,   1, 8'hA0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0,   1, 8'hB1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0,   0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hC3, 0, 8'h00, 1, 0,   0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hC4, 0, 8'h00, 1, 0,   0, 8'h00, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'hC5, 0, 8'h00, 1, 0,   0, 8'h00, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 0,   0, 8'h00, 1, 0, 2, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0,   1, 8'hC3, 1, 0, 2, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0,   0, 8'h00, 0, 0, 2, 0));
        tbl.push_back(mk(0, 1, 8'h11, 1, 8'h22, 1, 0,   0, 8'h00, 0, 0, 2, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 0,   0, 8'h00, 1, 1, 2, 0));
        tbl.push_back(mk(1, 0, 8'h00, 0, 8'h00, 1, 0,   0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0,   0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0,   0, 8'h00, 0, 0, 0, 0));

        @(negedge clk);
        foreach (tbl[i]) begin
            rst = tbl[i].rst; stb0 = tbl[i].s0; d0 = tbl[i].d0; stb1 = tbl[i].s1;
            d1 = tbl[i].d1; full = tbl[i].full; clr = tbl[i].clr;
            #2;
            chk($sformatf("tbl%0d_write", i), 32'(wr),  32'(tbl[i].e_wr));
            chk($sformatf("tbl%0d_wdata", i), 32'(wd),  32'(tbl[i].e_wd));
            chk($sformatf("tbl%0d_pend0", i), 32'(p0),  32'(tbl[i].e_p0));
            chk($sformatf("tbl%0d_pend1", i), 32'(p1),  32'(tbl[i].e_p1));
            chk($sformatf("tbl%0d_drop0", i), 32'(dr0), 32'(tbl[i].e_r0));
            chk($sformatf("tbl%0d_drop1", i), 32'(dr1), 32'(tbl[i].e_r1));
            @(negedge clk);
        end

        // ---------------- sustained alternation ----------------
        // Each producer re-strobes on the cycle its slot drains: 20 words each.
        rst = 1; stb0 = 0; stb1 = 0; full = 0; clr = 0;
        @(negedge clk);
        rst = 0;
        n_wr = 0;
        for (int c = 0; c <= 41; c++) begin
            stb0 = (c == 0) || ((c % 2 == 1) && (c <= 37));
            d0   = 8'h10 + 8'((c + 1) / 2);
            stb1 = (c % 2 == 0) && (c <= 38);
            d1   = 8'h80 + 8'(c / 2);
            #2;
            if (c >= 1 && c <= 40) begin
                chk($sformatf("alt%0d_write", c), 32'(wr), 32'd1);
                if (c % 2 == 1) chk($sformatf("alt%0d_wdata", c), 32'(wd), 32'(8'h10 + 8'((c - 1) / 2)));
                else            chk($sformatf("alt%0d_wdata", c), 32'(wd), 32'(8'h80 + 8'((c - 2) / 2)));
            end else if (c == 41) begin
                chk("alt_idle_write", 32'(wr), 32'd0);
            end
            if (wr) n_wr++;
            @(negedge clk);
        end
        stb0 = 0; stb1 = 0;
        chk("alt_write_count", 32'(n_wr), 32'd40);
        chk("alt_drop0", 32'(dr0), 32'd0);
        chk("alt_drop1", 32'(dr1), 32'd0);

        // ---------------- saturation on 2-bit counters ----------------
        rst_b = 0; full_b = 1;
        for (int k = 0; k < 6; k++) begin
            stb1_b = 1; d1_b = 8'h50 + 8'(k);
            #2;
            chk($sformatf("sat%0d_drop1", k), 32'(dr1_b), (k < 2) ? 32'd0 : ((k - 1 > 3) ? 32'd3 : 32'(k - 1)));
            @(negedge clk);
        end
        stb1_b = 0;
        #2;
        chk("sat_final_drop1", 32'(dr1_b), 32'd3);
        chk("sat_pend1", 32'(p1_b), 32'd1);
        chk("sat_no_write", 32'(wr_b), 32'd0);
        @(negedge clk);
        stb1_b = 1; d1_b = 8'h77; clr_b = 1;
        @(negedge clk);
        stb1_b = 0; clr_b = 0;
        #2;
        chk("clr_prio_drop1", 32'(dr1_b), 32'd0);
        @(negedge clk);
        full_b = 0;
        #2;
        chk("sat_release_write", 32'(wr_b), 32'd1);
        chk("sat_release_wdata", 32'(wd_b), 32'h50);
        @(negedge clk);

        // ---------------- randomized traffic vs model ----------------
        rst = 1; stb0 = 0; stb1 = 0; full = 0; clr = 0;
        model_reset();
        @(negedge clk);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst  = ($urandom_range(0, 63) == 0);
            stb0 = $urandom_range(0, 1) == 1;
            stb1 = $urandom_range(0, 1) == 1;
            d0   = 8'($urandom);
            d1   = 8'($urandom);
            full = ($urandom_range(0, 3) == 0);
            clr  = ($urandom_range(0, 31) == 0);
            #2;
            model_eval(rst, full);
            chk("rnd_write", 32'(wr),  32'(e_wr));
            chk("rnd_wdata", 32'(wd),  32'(e_wd));
            chk("rnd_pend0", 32'(p0),  rst ? 32'd0 : 32'(m_pend[0]));
            chk("rnd_pend1", 32'(p1),  rst ? 32'd0 : 32'(m_pend[1]));
            chk("rnd_drop0", 32'(dr0), rst ? 32'd0 : 32'(m_drops[0]));
            chk("rnd_drop1", 32'(dr1), rst ? 32'd0 : 32'(m_drops[1]));
            model_step(rst, stb0, d0, stb1, d1, clr);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
